// File: rtl/aes_pkg.sv
// Shared AES definitions for the encipher/decipher round blocks.
//   - keylen encodings and round counts
//   - control FSM state codes and state-register update-type codes
//   - GF(2^8) helpers (gm2, gm3), column mix (mixw), ShiftRows on a
//     128-bit state laid out as {w0,w1,w2,w3}, each word one column
package aes_pkg;

   localparam logic [1:0] KEYLEN_128 = 2'b00;
   localparam logic [1:0] KEYLEN_256 = 2'b01;
   localparam logic [1:0] KEYLEN_192 = 2'b10;

   localparam logic [3:0] AES128_ROUNDS = 4'd10;
   localparam logic [3:0] AES192_ROUNDS = 4'd12;
   localparam logic [3:0] AES256_ROUNDS = 4'd14;

   typedef enum logic [1:0] {
      CTRL_IDLE,
      CTRL_INIT,
      CTRL_SBOX,
      CTRL_MAIN
   } ctrl_state_t;

   typedef enum logic [2:0] {
      UPD_NONE,
      UPD_INIT,
      UPD_SBOX,
      UPD_MAIN,
      UPD_FINAL
   } upd_type_t;

   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction

   // One column through the {2,3,1,1} circulant matrix.
   function automatic logic [31:0] mixw(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      b0 = w[31:24];
      b1 = w[23:16];
      b2 = w[15:8];
      b3 = w[7:0];
      return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
              b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
              b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
              gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
   endfunction

   function automatic logic [127:0] mixcolumns(input logic [127:0] d);
      return {mixw(d[127:96]), mixw(d[95:64]), mixw(d[63:32]), mixw(d[31:0])};
   endfunction

   // Row r rotates left by r columns.
   function automatic logic [127:0] shiftrows(input logic [127:0] d);
      logic [31:0] w0, w1, w2, w3;
      w0 = d[127:96];
      w1 = d[95:64];
      w2 = d[63:32];
      w3 = d[31:0];
      return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
              w1[31:24], w2[23:16], w3[15:8], w0[7:0],
              w2[31:24], w3[23:16], w0[15:8], w1[7:0],
              w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
   endfunction

endpackage

// File: rtl/aes_enc_round_dp.sv
// Combinational encipher round datapath.
//   i_block     : plaintext            -> o_init  = block ^ key
//   i_state     : current state        -> o_main  = MixColumns(ShiftRows(state)) ^ key
//   i_round_key : round key            -> o_final = ShiftRows(state) ^ key
module aes_enc_round_dp
   import aes_pkg::*;
(
   input  logic [127:0] i_block,
   input  logic [127:0] i_state,
   input  logic [127:0] i_round_key,
   output logic [127:0] o_init,
   output logic [127:0] o_main,
   output logic [127:0] o_final
);

   logic [127:0] w_shifted;

   assign w_shifted = shiftrows(i_state);
   assign o_init    = i_block ^ i_round_key;
   assign o_main    = mixcolumns(w_shifted) ^ i_round_key;
   assign o_final   = w_shifted ^ i_round_key;

endmodule

// File: rtl/aes_encipher_block_par.sv
// Iterative AES encipher block with SBOX_WORDS parallel S-box lanes.
//   clk, reset_n          : clock, async active-low reset
//   next, keylen          : start request (taken when ready), key length
//   round, round_key      : round index out, matching round key in
//   sboxw, new_sboxw      : S-box lanes out / substituted lanes in
//   block, new_block      : plaintext in, state/ciphertext out
//   ready, done           : idle flag, one-cycle completion pulse
module aes_encipher_block_par
   import aes_pkg::*;
#(
   parameter int unsigned SBOX_WORDS = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    next,
   input  logic [1:0]              keylen,
   output logic [3:0]              round,
   input  logic [127:0]            round_key,
   output logic [32*SBOX_WORDS-1:0] sboxw,
   input  logic [32*SBOX_WORDS-1:0] new_sboxw,
   input  logic [127:0]            block,
   output logic [127:0]            new_block,
   output logic                    ready,
   output logic                    done
);

   if (!(SBOX_WORDS == 1 || SBOX_WORDS == 2 || SBOX_WORDS == 4)) begin : g_bad_param
      $error("SBOX_WORDS must be 1, 2 or 4");
   end

   localparam int unsigned SCYCLES    = 4 / SBOX_WORDS;
   localparam logic [1:0]  SWORD_LAST = 2'(SCYCLES - 1);

   ctrl_state_t r_state, w_state_nxt;
   logic [3:0]  r_round_ctr, w_round_nxt;
   logic [1:0]  r_sword_ctr, w_sword_nxt;
   logic [1:0]  r_keylen, w_keylen_nxt;
   logic        r_ready, w_ready_nxt;
   logic        r_done, w_done_nxt;
   logic [31:0] r_w [4];
   logic [31:0] w_w_nxt [4];

   upd_type_t   w_upd;
   logic [3:0]  w_num_rounds;
   logic [127:0] w_init, w_main, w_final, w_cand;

   aes_enc_round_dp u_dp (
      .i_block     (block),
      .i_state     (new_block),
      .i_round_key (round_key),
      .o_init      (w_init),
      .o_main      (w_main),
      .o_final     (w_final)
   );

   assign new_block = {r_w[0], r_w[1], r_w[2], r_w[3]};
   assign round     = r_round_ctr;
   assign ready     = r_ready;
   assign done      = r_done;

   always_comb begin
      case (r_keylen)
         KEYLEN_256: w_num_rounds = AES256_ROUNDS;
         KEYLEN_192: w_num_rounds = AES192_ROUNDS;
         default:    w_num_rounds = AES128_ROUNDS;
      endcase
   end

   // Lane i reads word (sword_ctr*SBOX_WORDS + i) of the state.
   for (genvar gi = 0; gi < SBOX_WORDS; gi++) begin : g_lane
      logic [1:0] w_lane_idx;
      assign w_lane_idx = 2'(32'(r_sword_ctr) * SBOX_WORDS + gi);
      assign sboxw[32*gi +: 32] = (r_state == CTRL_SBOX) ? r_w[w_lane_idx] : '0;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_round_nxt  = r_round_ctr;
      w_sword_nxt  = r_sword_ctr;
      w_keylen_nxt = r_keylen;
      w_ready_nxt  = r_ready;
      w_done_nxt   = 1'b0;
      w_upd        = UPD_NONE;
      case (r_state)
         CTRL_IDLE: begin
            w_done_nxt = r_done & 1'b0;
            if (next) begin
               w_keylen_nxt = keylen;
               w_round_nxt  = 4'd0;
               w_ready_nxt  = 1'b0;
               w_state_nxt  = CTRL_INIT;
            end
         end
         CTRL_INIT: begin
            w_upd       = UPD_INIT;
            w_round_nxt = 4'd1;
            w_sword_nxt = 2'd0;
            w_state_nxt = CTRL_SBOX;
         end
         CTRL_SBOX: begin
            w_upd       = UPD_SBOX;
            w_sword_nxt = r_sword_ctr + 2'd1;
            if (r_sword_ctr == SWORD_LAST) w_state_nxt = CTRL_MAIN;
         end
         CTRL_MAIN: begin
            w_sword_nxt = 2'd0;
            w_round_nxt = r_round_ctr + 4'd1;
            if (r_round_ctr < w_num_rounds) begin
               w_upd       = UPD_MAIN;
               w_state_nxt = CTRL_SBOX;
            end else begin
               w_upd       = UPD_FINAL;
               w_ready_nxt = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = CTRL_IDLE;
            end
         end
         default: w_state_nxt = CTRL_IDLE;
      endcase
   end

   always_comb begin
      w_w_nxt = r_w;
      case (w_upd)
         UPD_INIT:  w_cand = w_init;
         UPD_MAIN:  w_cand = w_main;
         default:   w_cand = w_final;
      endcase
      if (w_upd == UPD_INIT || w_upd == UPD_MAIN || w_upd == UPD_FINAL) begin
         for (int unsigned j = 0; j < 4; j++) w_w_nxt[j] = w_cand[127-32*j -: 32];
      end else if (w_upd == UPD_SBOX) begin
         for (int unsigned j = 0; j < 4; j++) begin
            if ((j / SBOX_WORDS) == 32'(r_sword_ctr))
               w_w_nxt[j] = new_sboxw[32*(j % SBOX_WORDS) +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= CTRL_IDLE;
         r_round_ctr <= '0;
         r_sword_ctr <= '0;
         r_keylen    <= KEYLEN_128;
         r_ready     <= 1'b1;
         r_done      <= 1'b0;
         for (int unsigned j = 0; j < 4; j++) r_w[j] <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_round_ctr <= w_round_nxt;
         r_sword_ctr <= w_sword_nxt;
         r_keylen    <= w_keylen_nxt;
         r_ready     <= w_ready_nxt;
         r_done      <= w_done_nxt;
         r_w         <= w_w_nxt;
      end
   end

endmodule

// File: tb/tb_aes_encipher_block_par.sv
module tb_aes_encipher_block_par;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // Index 0: SBOX_WORDS=1, 1: SBOX_WORDS=2, 2: SBOX_WORDS=4.
   logic         next_s [3];
   logic [1:0]   keylen_s [3];
   logic [3:0]   round_s [3];
   logic [127:0] rkey_s [3];
   logic [127:0] block_s [3];
   logic [127:0] nb_s [3];
   logic         ready_s [3];
   logic         done_s [3];
   logic [127:0] rk [3][16];

   logic [31:0]  sbw1, nsb1;
   logic [63:0]  sbw2, nsb2;
   logic [127:0] sbw4, nsb4;

   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX_TBL[2047 - 8*b -: 8];
   endfunction

   function automatic logic [31:0] sub32(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   always_comb begin
      nsb1 = sub32(sbw1);
      nsb2 = {sub32(sbw2[63:32]), sub32(sbw2[31:0])};
      nsb4 = {sub32(sbw4[127:96]), sub32(sbw4[95:64]), sub32(sbw4[63:32]), sub32(sbw4[31:0])};
      for (int i = 0; i < 3; i++) rkey_s[i] = rk[i][round_s[i]];
   end

   aes_encipher_block_par #(.SBOX_WORDS(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .next(next_s[0]), .keylen(keylen_s[0]),
      .round(round_s[0]), .round_key(rkey_s[0]), .sboxw(sbw1), .new_sboxw(nsb1),
      .block(block_s[0]), .new_block(nb_s[0]), .ready(ready_s[0]), .done(done_s[0]));

   aes_encipher_block_par #(.SBOX_WORDS(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .next(next_s[1]), .keylen(keylen_s[1]),
      .round(round_s[1]), .round_key(rkey_s[1]), .sboxw(sbw2), .new_sboxw(nsb2),
      .block(block_s[1]), .new_block(nb_s[1]), .ready(ready_s[1]), .done(done_s[1]));

   aes_encipher_block_par #(.SBOX_WORDS(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .next(next_s[2]), .keylen(keylen_s[2]),
      .round(round_s[2]), .round_key(rkey_s[2]), .sboxw(sbw4), .new_sboxw(nsb4),
      .block(block_s[2]), .new_block(nb_s[2]), .ready(ready_s[2]), .done(done_s[2]));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // FIPS-197 key expansion into rk[k][0..nr].
   task automatic expand_key(input int k, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = KEY[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = sub32({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub32(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rk[k][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one operation on DUT k and wait for done. With disturb set,
   // keylen flips to 00 and next pulses mid-run; both must be ignored.
   task automatic run_op(input int k, input logic [1:0] kl, input logic [127:0] ct,
                         input int exp_n, input bit disturb, input string tag);
      int n;
      int extra;
      logic [127:0] held;
      block_s[k]  = PT;
      keylen_s[k] = kl;
      next_s[k]   = 1'b1;
      tick();
      next_s[k] = 1'b0;
      check({tag, "_busy"}, 128'(ready_s[k]), 128'd0);
      if (k == 2) check({tag, "_sboxw_init"}, sbw4, '0);
      n = 0;
      while (done_s[k] !== 1'b1 && n < 300) begin
         if (disturb && n == 10) begin keylen_s[k] = 2'b00; next_s[k] = 1'b1; end
         if (disturb && n == 11) next_s[k] = 1'b0;
         tick();
         n++;
         if (k == 2 && n % 2 == 0 && done_s[k] !== 1'b1) check({tag, "_sboxw_main"}, sbw4, '0);
      end
      check({tag, "_edges"}, 128'(n), 128'(exp_n));
      check({tag, "_ct"}, nb_s[k], ct);
      check({tag, "_ready"}, 128'(ready_s[k]), 128'd1);
      held  = nb_s[k];
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done_s[k] === 1'b1) extra++;
      end
      check({tag, "_one_done"}, 128'(extra), 128'd0);
      check({tag, "_hold"}, nb_s[k], held);
   endtask

   initial begin
      int n;
      int dseen;
      for (int i = 0; i < 3; i++) begin
         next_s[i] = 1'b0; keylen_s[i] = 2'b00; block_s[i] = '0;
      end
      expand_key(0, 4);
      expand_key(1, 6);
      expand_key(2, 8);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_ready%0d", i), 128'(ready_s[i]), 128'd1);
         check($sformatf("rst_done%0d", i), 128'(done_s[i]), 128'd0);
         check($sformatf("rst_round%0d", i), 128'(round_s[i]), 128'd0);
         check($sformatf("rst_block%0d", i), nb_s[i], '0);
      end
      check("rst_sboxw", {sbw1, sbw2, 32'h0}, '0);

      run_op(0, 2'b00, CT128, 51, 1'b0, "aes128_n1");
      run_op(1, 2'b10, CT192, 37, 1'b0, "aes192_n2");
      run_op(2, 2'b01, CT256, 29, 1'b0, "aes256_n4");
      run_op(2, 2'b01, CT256, 29, 1'b1, "keylen_change");

      // Reset mid-operation on the N=1 instance.
      block_s[0] = PT; keylen_s[0] = 2'b00; next_s[0] = 1'b1;
      tick();
      next_s[0] = 1'b0;
      dseen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done_s[0] === 1'b1) dseen++;
      end
      reset_n = 1'b0;
      #1;
      check("midrst_ready", 128'(ready_s[0]), 128'd1);
      check("midrst_block", nb_s[0], '0);
      check("midrst_round", 128'(round_s[0]), 128'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done_s[0] === 1'b1) dseen++;
      end
      check("midrst_no_done", 128'(dseen), 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      run_op(0, 2'b00, CT128, 51, 1'b0, "after_rst");

      // Back-to-back with next held high; first op uses the reserved keylen.
      block_s[0] = PT; keylen_s[0] = 2'b11; next_s[0] = 1'b1;
      tick();
      keylen_s[0] = 2'b00;
      n = 0;
      while (done_s[0] !== 1'b1 && n < 300) begin tick(); n++; end
      check("b2b_first_edges", 128'(n), 128'd51);
      check("b2b_first_ct", nb_s[0], CT128);
      tick();
      n++;
      check("b2b_restart_ready", 128'(ready_s[0]), 128'd0);
      check("b2b_done_pulse", 128'(done_s[0]), 128'd0);
      while (done_s[0] !== 1'b1 && n < 400) begin tick(); n++; end
      next_s[0] = 1'b0;
      check("b2b_second_edges", 128'(n), 128'd103);
      check("b2b_second_ct", nb_s[0], CT128);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
